td4_core: RTL and testbench
===========================

// Module: td4_core
// PURPOSE
//  Parametrised single-cycle accumulator CPU core. Combines register file, source
//  selector and adder-with-immediate with a program counter, carry flag,
//  instruction decode and I/O ports. One instruction retires per enabled clock.
//  Instruction ROM is external and combinational: core drives pc, ROM returns instr.
// PARAMETERS
//  DATA_W  4  register / immediate / port width; instr width = 4 + DATA_W
//  ADDR_W  4  program counter width; legal range 1..DATA_W (elaboration error otherwise)
// PORTS
//  clk         in   1           clock, rising edge
//  n_reset     in   1           asynchronous active-low reset
//  en          in   1           execute enable; 0 = freeze all state
//  instr       in   4+DATA_W    {op[3:0], im[DATA_W-1:0]} fetched from address pc
//  in_port     in   DATA_W      input port, sampled by IN instructions
//  pc          out  ADDR_W      current instruction address
//  out_port    out  DATA_W      registered output port
//  out_strobe  out  1           1-cycle pulse: out_port updated at this edge
//  carry       out  1           carry flag register
//  reg_a       out  DATA_W      register A (debug)
//  reg_b       out  DATA_W      register B (debug)
// BEHAVIOUR
//  - Reset (async, n_reset=0): pc, A, B, out_port = 0; carry, out_strobe = 0.
//    Asserting reset mid-program aborts the current instruction; no partial update.
//  - Per rising edge with en=1: execute instr; all writes and pc update occur at
//    that edge (zero-latency decode; result visible on outputs the next cycle).
//  - en=0: pc, A, B, carry, out_port hold; out_strobe = 0.
//  - ALU: {cout, sum} = src + im, (DATA_W+1)-bit add; src selected by op:
//    A, B, in_port, or zero. carry <= cout on EVERY executed instruction
//    (MOV/IN/JMP/OUT therefore clear carry unless src+im overflows).
//  - Opcodes (op -> action; src):
//    0000 ADD A,Im  A<=sum  (src A)    | 0101 ADD B,Im  B<=sum  (src B)
//    0011 MOV A,Im  A<=sum  (src 0)    | 0111 MOV B,Im  B<=sum  (src 0)
//    0001 MOV A,B   A<=sum  (src B)    | 0100 MOV B,A   B<=sum  (src A)
//    0010 IN A      A<=sum  (src in)   | 0110 IN B      B<=sum  (src in)
//    1001 OUT B     out_port<=sum (src B), out_strobe<=1
//    1011 OUT Im    out_port<=sum (src 0), out_strobe<=1
//    1111 JMP Im    pc<=im[ADDR_W-1:0]
//    1110 JNC Im    pc<=im[ADDR_W-1:0] if carry==0 (value BEFORE this edge), else pc+1
//    others: NOP; no register/port write, carry<=0, pc<=pc+1
//  - Software writes im verbatim; MOV/IN/OUT adding a nonzero im is legal and defined.
//  - pc<=pc+1 for every non-taken-branch instruction; wraps 2^ADDR_W-1 -> 0.
//  - ADD overflow: result modulo 2^DATA_W, carry=1 (e.g. DATA_W=4: F+1 -> 0, C=1).
//  - Jump target truncates im to ADDR_W LSBs; upper im bits ignored.
//  - out_strobe high exactly one cycle per executed OUT; back-to-back OUTs -> held high.
//  - in_port sampled only on the edge executing IN; no synchronizer inside.
// TESTING
//  1 Reset: n_reset low async mid-cycle -> pc=0,A=B=0,carry=0,out_port=0,strobe=0 at once.
//  2 ADD overflow (DATA_W=4): MOV A,0xE; ADD A,3 -> A=0x1, carry=1; next MOV A,0 -> carry=0.
//  3 JNC loop: MOV A,0xD; ADD A,1; JNC 1 -> loops until A=0x0 (carry=1), then pc falls to 3.
//  4 I/O: in_port=0x5; IN B; OUT B -> out_port=0x5, out_strobe high exactly 1 cycle.
//  5 PC wrap/JMP: run 16 NOPs from pc=0 -> pc=0 again; JMP 0xA -> pc=0xA.
//  6 en=0 for 3 cycles mid-program -> all outputs frozen, strobe=0; resume identical.
//  7 DATA_W=8,ADDR_W=6: ADD A,0xFF with A=0x01 -> A=0x00,carry=1; JMP 0xC5 -> pc=0x05.

Source files
------------

// File: rtl/td4_core_if.sv
// rtl/td4_core_if.sv - instruction ROM bus between the td4 core and its program store
// The core drives the fetch address; the ROM answers combinationally in the same cycle.
interface td4_core_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W+3:0]   instr;

   modport master (output pc, input instr);
   modport slave  (input pc, output instr);
endinterface

// File: rtl/td4_core.sv
// rtl/td4_core.sv - single-cycle accumulator CPU: A/B registers, carry, pc and I/O ports
// One instruction from the external ROM retires on every enabled rising edge.
module td4_core #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              en,
   td4_core_if.master        rom,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              out_strobe,
   output logic              carry,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b
);
   if (ADDR_W < 1 || ADDR_W > DATA_W) begin : g_bad_addr_w
      $error("td4_core: ADDR_W must lie in 1..DATA_W");
   end

   typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
   logic              carry_q, carry_d;
   logic              strobe_q;

   logic [3:0]        op;
   logic [DATA_W-1:0] im;
   logic [DATA_W-1:0] src;
   logic [DATA_W:0]   sum;
   src_e              src_sel;
   logic              wr_a, wr_b, wr_out, jump;

   assign op = rom.instr[DATA_W+3:DATA_W];
   assign im = rom.instr[DATA_W-1:0];

   always_comb begin
      src_sel = SRC_ZERO;
      wr_a    = 1'b0;
      wr_b    = 1'b0;
      wr_out  = 1'b0;
      jump    = 1'b0;
      case (op)
         4'b0000: begin src_sel = SRC_A;  wr_a = 1'b1; end
         4'b0001: begin src_sel = SRC_B;  wr_a = 1'b1; end
         4'b0010: begin src_sel = SRC_IN; wr_a = 1'b1; end
         4'b0011: wr_a = 1'b1;
         4'b0100: begin src_sel = SRC_A;  wr_b = 1'b1; end
         4'b0101: begin src_sel = SRC_B;  wr_b = 1'b1; end
         4'b0110: begin src_sel = SRC_IN; wr_b = 1'b1; end
         4'b0111: wr_b = 1'b1;
         4'b1001: begin src_sel = SRC_B;  wr_out = 1'b1; end
         4'b1011: wr_out = 1'b1;
         4'b1111: jump = 1'b1;
         // JNC tests the flag as it stood before this edge
         4'b1110: jump = ~carry_q;
         default: ;
      endcase
   end

   always_comb begin
      case (src_sel)
         SRC_A:   src = a_q;
         SRC_B:   src = b_q;
         SRC_IN:  src = in_port;
         default: src = '0;
      endcase
   end

   // Branches and NOPs select the zero source, so their cout is always 0
   assign sum = {1'b0, src} + {1'b0, im};

   always_comb begin
      pc_d    = jump ? im[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      a_d     = wr_a   ? sum[DATA_W-1:0] : a_q;
      b_d     = wr_b   ? sum[DATA_W-1:0] : b_q;
      out_d   = wr_out ? sum[DATA_W-1:0] : out_q;
      carry_d = sum[DATA_W];
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pc_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         out_q    <= '0;
         carry_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else if (en) begin
         pc_q     <= pc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         out_q    <= out_d;
         carry_q  <= carry_d;
         strobe_q <= wr_out;
      end else begin
         strobe_q <= 1'b0;
      end
   end

   assign rom.pc     = pc_q;
   assign out_port   = out_q;
   assign out_strobe = strobe_q;
   assign carry      = carry_q;
   assign reg_a      = a_q;
   assign reg_b      = b_q;
endmodule

// File: tb/tb_td4_core.sv
// tb/tb_td4_core.sv - td4_core bench: instruction-level model plus directed programs
// A 4/4 core is checked every cycle against the model; an 8/6 core gets literal checks.
module tb_td4_core;
   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       en = 1'b0;
   logic       en2 = 1'b0;
   logic [3:0] in_port = 4'h0;
   logic       cmp_on = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   logic [7:0]  prog [16];
   logic [11:0] prog2 [64];

   logic [3:0] out1, a1, b1;
   logic       strb1, c1;
   logic [7:0] out2, a2, b2;
   logic       strb2, c2;

   td4_core_if #(.DATA_W(4), .ADDR_W(4)) rom1 ();
   td4_core_if #(.DATA_W(8), .ADDR_W(6)) rom2 ();

   assign rom1.instr = prog[rom1.pc];
   assign rom2.instr = prog2[rom2.pc];

   td4_core #(.DATA_W(4), .ADDR_W(4)) dut (
      .clk(clk), .n_reset(n_reset), .en(en), .rom(rom1), .in_port(in_port),
      .out_port(out1), .out_strobe(strb1), .carry(c1), .reg_a(a1), .reg_b(b1));

   td4_core #(.DATA_W(8), .ADDR_W(6)) dut2 (
      .clk(clk), .n_reset(n_reset), .en(en2), .rom(rom2), .in_port(8'h00),
      .out_port(out2), .out_strobe(strb2), .carry(c2), .reg_a(a2), .reg_b(b2));

   always #5 clk = ~clk;

   typedef struct packed {
      int pc; int a; int b; int c; int out; int strb;
   } mstate_t;

   mstate_t m;

   // Architectural effect of one instruction on a 4-bit machine
   function automatic mstate_t step(mstate_t s, logic [7:0] ins, int inp);
      mstate_t n = s;
      int im = int'(ins[3:0]);
      n.pc = (s.pc + 1) % 16;
      n.strb = 0;
      n.c = 0;
      case (ins[7:4])
         4'h0: begin n.a = (s.a + im) % 16; n.c = (s.a + im) / 16; end
         4'h1: begin n.a = (s.b + im) % 16; n.c = (s.b + im) / 16; end
         4'h2: begin n.a = (inp + im) % 16; n.c = (inp + im) / 16; end
         4'h3: n.a = im;
         4'h4: begin n.b = (s.a + im) % 16; n.c = (s.a + im) / 16; end
         4'h5: begin n.b = (s.b + im) % 16; n.c = (s.b + im) / 16; end
         4'h6: begin n.b = (inp + im) % 16; n.c = (inp + im) / 16; end
         4'h7: n.b = im;
         4'h9: begin n.out = (s.b + im) % 16; n.c = (s.b + im) / 16; n.strb = 1; end
         4'hB: begin n.out = im; n.strb = 1; end
         4'hF: n.pc = im;
         4'hE: if (s.c == 0) n.pc = im;
         default: ;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         m <= '0;
      else if (en)
         m <= step(m, prog[m.pc], int'(in_port));
      else
         m.strb <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on && n_reset) begin
         chk("model pc",     32'(rom1.pc), m.pc);
         chk("model reg_a",  32'(a1),      m.a);
         chk("model reg_b",  32'(b1),      m.b);
         chk("model carry",  32'(c1),      m.c);
         chk("model out",    32'(out1),    m.out);
         chk("model strobe", 32'(strb1),   m.strb);
      end
   end

   task automatic cyc(input logic e, input logic [3:0] inp);
      en = e;
      in_port = inp;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      prog[0] = 8'h3E; prog[1] = 8'h03; prog[2] = 8'h30; prog[3] = 8'h3D;
      prog[4] = 8'h01; prog[5] = 8'hE4; prog[6] = 8'h60; prog[7] = 8'h90;
      prog[8] = 8'hB7; prog[9] = 8'h80; prog[10] = 8'hF0;
      for (int i = 11; i < 16; i++) prog[i] = 8'h80;
      for (int i = 0; i < 64; i++) prog2[i] = 12'h800;
      prog2[0] = 12'h301; prog2[1] = 12'h0FF; prog2[2] = 12'hFC5;

      repeat (2) @(posedge clk);
      #1;
      chk("reset pc", 32'(rom1.pc), 0);
      chk("reset strobe", 32'(strb1), 0);
      @(negedge clk);
      #1;
      n_reset = 1'b1;
      cmp_on = 1'b1;

      cyc(1, 4'h0);
      cyc(1, 4'h0);
      chk("add ovf a", 32'(a1), 1);
      chk("add ovf carry", 32'(c1), 1);
      cyc(1, 4'h0);
      chk("mov clears carry", 32'(c1), 0);
      repeat (6) cyc(1, 4'h0);
      chk("loop end a", 32'(a1), 0);
      chk("loop end carry", 32'(c1), 1);
      chk("loop end pc", 32'(rom1.pc), 5);
      cyc(1, 4'h0);
      chk("jnc fallthrough pc", 32'(rom1.pc), 6);
      chk("jnc carry", 32'(c1), 0);
      cyc(1, 4'h5);
      chk("in b", 32'(b1), 5);
      cyc(1, 4'hA);
      chk("out b port", 32'(out1), 5);
      chk("out b strobe", 32'(strb1), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'h3);
         chk("freeze pc", 32'(rom1.pc), 8);
         chk("freeze strobe", 32'(strb1), 0);
         chk("freeze out", 32'(out1), 5);
      end
      cyc(1, 4'h0);
      chk("out im port", 32'(out1), 7);
      chk("out im strobe", 32'(strb1), 1);
      cyc(1, 4'h0);
      chk("strobe drops", 32'(strb1), 0);
      cyc(1, 4'h0);
      chk("jmp 0 pc", 32'(rom1.pc), 0);
      cyc(1, 4'h0);
      cyc(1, 4'h0);

      #2;
      n_reset = 1'b0;
      #1;
      chk("async rst pc", 32'(rom1.pc), 0);
      chk("async rst a", 32'(a1), 0);
      chk("async rst b", 32'(b1), 0);
      chk("async rst carry", 32'(c1), 0);
      chk("async rst out", 32'(out1), 0);
      chk("async rst strobe", 32'(strb1), 0);

      prog[0] = 8'h3F;
      prog[1] = 8'h01;
      for (int i = 2; i < 16; i++) begin
         case (i % 4)
            0: prog[i] = {4'h8, 4'(i)};
            1: prog[i] = {4'hA, 4'(i)};
            2: prog[i] = {4'hC, 4'(i)};
            default: prog[i] = {4'hD, 4'(i)};
         endcase
      end
      @(negedge clk);
      #1;
      n_reset = 1'b1;
      repeat (16) cyc(1, 4'h0);
      chk("wrap pc", 32'(rom1.pc), 0);
      chk("nop clears carry", 32'(c1), 0);
      chk("nop keeps a", 32'(a1), 0);
      prog[0] = 8'hFA;
      cyc(1, 4'h0);
      chk("jmp a pc", 32'(rom1.pc), 10);

      en2 = 1'b1;
      cyc(1, 4'h0);
      chk("w8 mov a", 32'(a2), 32'h01);
      cyc(1, 4'h0);
      chk("w8 add a", 32'(a2), 32'h00);
      chk("w8 add carry", 32'(c2), 1);
      cyc(1, 4'h0);
      chk("w8 jmp pc", 32'(rom2.pc), 32'h05);
      chk("w8 jmp carry", 32'(c2), 0);
      en2 = 1'b0;

      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
